// File: rtl/bkm_z_accum.sv
// BKM z-accumulator: iterates z(n+1) = z(n) + (d(n)*z(n)) >>> n over N_ITER
// digits supplied by an upstream selector, using an external multiply_by_d
// block for the complex product z*d.
module bkm_z_accum #(
  parameter int W      = 64,
  parameter int N_ITER = 64,
  parameter int CNT_W  = 7
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [W-1:0]     z0_x,
  input  logic [W-1:0]     z0_y,
  output logic             busy,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic [1:0]       d_x_in,
  input  logic [1:0]       d_y_in,
  output logic [CNT_W-1:0] iter,
  output logic [1:0]       md_d_x,
  output logic [1:0]       md_d_y,
  output logic [W-1:0]     md_x_in,
  output logic [W-1:0]     md_y_in,
  input  logic [W-1:0]     md_x_out,
  input  logic [W-1:0]     md_y_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_x,
  output logic [W-1:0]     res_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITER - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic signed [W-1:0]    z_x;
  logic signed [W-1:0]    z_y;
  logic [CNT_W-1:0]       n;
  logic                   accept;

  // Scaled accumulate: the product is shifted arithmetically so negative
  // terms stay negative; the sum wraps modulo 2^W by construction.
  function automatic logic signed [W-1:0] acc_shift(
    input logic signed [W-1:0] acc,
    input logic signed [W-1:0] prod,
    input logic [CNT_W-1:0]    sh
  );
    return acc + (prod >>> sh);
  endfunction

  assign accept = (state == ITER) && d_valid;

  // Digit and current z go straight to the external multiplier.
  assign md_d_x   = d_x_in;
  assign md_d_y   = d_y_in;
  assign md_x_in  = z_x;
  assign md_y_in  = z_y;
  assign res_x    = z_x;
  assign res_y    = z_y;
  assign iter     = n;

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    d_ready   = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ITER;
      end
      ITER: begin
        busy    = 1'b1;
        d_ready = 1'b1;
        if (d_valid && (n == LAST)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // z and iteration counter: load on start, accumulate on each accepted digit;
  // n saturates at the last index so iter still reads N_ITER-1 in DONE.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      z_x <= '0;
      z_y <= '0;
      n   <= '0;
    end else if ((state == IDLE) && start) begin
      z_x <= $signed(z0_x);
      z_y <= $signed(z0_y);
      n   <= '0;
    end else if (accept) begin
      z_x <= acc_shift(z_x, $signed(md_x_out), n);
      z_y <= acc_shift(z_y, $signed(md_y_out), n);
      if (n != LAST) n <= n + 1'b1;
    end
  end

endmodule

// File: tb/tb_bkm_z_accum.sv
// Directed bench for bkm_z_accum (W=16, N_ITER=4) with a behavioural
// multiply_by_d attached.
module tb_bkm_z_accum;

  localparam int W      = 16;
  localparam int N_ITER = 4;
  localparam int CNT_W  = 3;

  logic             clk = 1'b0;
  logic             arst_n;
  logic             start;
  logic [W-1:0]     z0_x, z0_y;
  logic             busy;
  logic             d_valid;
  logic             d_ready;
  logic [1:0]       d_x_in, d_y_in;
  logic [CNT_W-1:0] iter;
  logic [1:0]       md_d_x, md_d_y;
  logic [W-1:0]     md_x_in, md_y_in;
  logic [W-1:0]     md_x_out, md_y_out;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_x, res_y;

  int checks   = 0;
  int failures = 0;

  bkm_z_accum #(.W(W), .N_ITER(N_ITER), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .z0_x(z0_x), .z0_y(z0_y),
    .busy(busy), .d_valid(d_valid), .d_ready(d_ready),
    .d_x_in(d_x_in), .d_y_in(d_y_in), .iter(iter),
    .md_d_x(md_d_x), .md_d_y(md_d_y), .md_x_in(md_x_in), .md_y_in(md_y_in),
    .md_x_out(md_x_out), .md_y_out(md_y_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y)
  );

  always #5 clk = ~clk;

  // multiply_by_d: (zx + j zy) * (dx + j dy), wrapped to W bits
  function automatic int dval(input logic [1:0] d);
    case (d)
      2'b01:   return 1;
      2'b10:   return -1;
      default: return 0;
    endcase
  endfunction

  int ax, ay;
  always_comb begin
    ax = int'($signed(md_x_in));
    ay = int'($signed(md_y_in));
    md_x_out = 16'(ax * dval(md_d_x) - ay * dval(md_d_y));
    md_y_out = 16'(ax * dval(md_d_y) + ay * dval(md_d_x));
  end

  // digit k at dx/dy[2k+:2]; expected z after step k at sx/sy[16k+:16]
  typedef struct {
    logic [15:0] z0x;
    logic [15:0] z0y;
    logic [7:0]  dx;
    logic [7:0]  dy;
    int          gap;
    logic [63:0] sx;
    logic [63:0] sy;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int i, input int hold);
    logic [15:0] px, py;
    start = 1'b1;
    z0_x  = vt[i].z0x;
    z0_y  = vt[i].z0y;
    tick();
    start = 1'b0;
    chk("load_busy", 16'(busy), 16'd1);
    chk("load_ready", 16'(d_ready), 16'd1);
    chk("load_iter", 16'(iter), 16'd0);
    chk("load_zx", md_x_in, vt[i].z0x);
    chk("load_zy", md_y_in, vt[i].z0y);
    px = vt[i].z0x;
    py = vt[i].z0y;
    for (int k = 0; k < N_ITER; k++) begin
      for (int g = 0; g < vt[i].gap; g++) begin
        d_valid = 1'b0;
        start   = 1'b1;
        z0_x    = 16'h5555;
        d_x_in  = 2'b01;
        d_y_in  = 2'b01;
        tick();
        start = 1'b0;
        chk("stall_zx", md_x_in, px);
        chk("stall_zy", md_y_in, py);
        chk("stall_iter", 16'(iter), 16'(k));
      end
      d_valid = 1'b1;
      d_x_in  = vt[i].dx[2*k +: 2];
      d_y_in  = vt[i].dy[2*k +: 2];
      tick();
      d_valid = 1'b0;
      px = vt[i].sx[16*k +: 16];
      py = vt[i].sy[16*k +: 16];
      chk("step_zx", md_x_in, px);
      chk("step_zy", md_y_in, py);
      if (k < N_ITER - 1) begin
        chk("step_iter", 16'(iter), 16'(k + 1));
        chk("step_res_valid", 16'(res_valid), 16'd0);
      end else begin
        chk("done_res_valid", 16'(res_valid), 16'd1);
        chk("done_res_x", res_x, px);
        chk("done_res_y", res_y, py);
        chk("done_iter", 16'(iter), 16'(N_ITER - 1));
        chk("done_ready", 16'(d_ready), 16'd0);
        chk("done_busy", 16'(busy), 16'd1);
      end
    end
    for (int h = 0; h < hold; h++) begin
      start     = 1'b1;
      z0_x      = 16'hAAAA;
      d_valid   = 1'b1;
      d_x_in    = 2'b01;
      res_ready = 1'b0;
      tick();
      chk("hold_res_valid", 16'(res_valid), 16'd1);
      chk("hold_res_x", res_x, px);
      chk("hold_res_y", res_y, py);
      chk("hold_iter", 16'(iter), 16'(N_ITER - 1));
    end
    start     = (hold > 0);
    d_valid   = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    chk("release_res_valid", 16'(res_valid), 16'd0);
    chk("release_busy", 16'(busy), 16'd0);
    chk("release_ready", 16'(d_ready), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{16'h1000, 16'h0000, 8'b10000001, 8'b00000100, 0,
              64'h1C00_2000_2000_2000, 64'h0E00_1000_1000_0000};
    vt[1] = '{16'h1000, 16'h0000, 8'b10000001, 8'b00000100, 3,
              64'h1C00_2000_2000_2000, 64'h0E00_1000_1000_0000};
    vt[2] = '{16'h7FFF, 16'h0000, 8'b00000001, 8'b00000000, 0,
              64'hFFFE_FFFE_FFFE_FFFE, 64'h0000_0000_0000_0000};
    vt[3] = '{16'h8000, 16'h0000, 8'b01000010, 8'b00000000, 0,
              64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
    vt[4] = '{16'hC000, 16'h4000, 8'b00000000, 8'b01000000, 0,
              64'hB800_C000_C000_C000, 64'h3800_4000_4000_4000};
    vt[5] = '{16'h0100, 16'h0200, 8'b10010011, 8'b10011011, 0,
              64'h0228_0220_0200_0100, 64'h01D0_0260_0180_0200};

    arst_n    = 1'b0;
    start     = 1'b0;
    z0_x      = '0;
    z0_y      = '0;
    d_valid   = 1'b0;
    d_x_in    = 2'b00;
    d_y_in    = 2'b00;
    res_ready = 1'b0;
    repeat (2) tick();

    // reset state, with start held active
    start = 1'b1;
    z0_x  = 16'h1234;
    tick();
    start = 1'b0;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_ready", 16'(d_ready), 16'd0);
    chk("rst_res_valid", 16'(res_valid), 16'd0);
    chk("rst_iter", 16'(iter), 16'd0);
    chk("rst_zx", md_x_in, 16'h0000);
    chk("rst_res_x", res_x, 16'h0000);
    arst_n = 1'b1;

    // digits are ignored in IDLE
    d_valid = 1'b1;
    d_x_in  = 2'b01;
    tick();
    d_valid = 1'b0;
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_iter", 16'(iter), 16'd0);
    chk("idle_zx", md_x_in, 16'h0000);

    for (int i = 0; i < 6; i++) run_op(i, 0);

    // result backpressure with start pulses and digits offered in DONE
    run_op(0, 5);

    // reset mid-operation after two accepts
    start = 1'b1;
    z0_x  = vt[5].z0x;
    z0_y  = vt[5].z0y;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_valid = 1'b1;
      d_x_in  = vt[5].dx[2*k +: 2];
      d_y_in  = vt[5].dy[2*k +: 2];
      tick();
    end
    d_valid = 1'b0;
    chk("mid_zx", md_x_in, 16'h0200);
    chk("mid_iter", 16'(iter), 16'd2);
    arst_n = 1'b0;
    #1;
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_ready", 16'(d_ready), 16'd0);
    chk("arst_res_valid", 16'(res_valid), 16'd0);
    chk("arst_iter", 16'(iter), 16'd0);
    chk("arst_zx", md_x_in, 16'h0000);
    chk("arst_zy", md_y_in, 16'h0000);
    #1;
    arst_n = 1'b1;
    run_op(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
